// File: rtl/game_pkg.sv
// Shared types and constants for the puck-game flow controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        PLAY,
        PAUSE,
        MISS,
        OVER
    } state_t;

    localparam int BCD_W = 4;
    localparam logic [15:0] SCORE_MAX = 16'h9999;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int MISS_FRAMES_DEF = 30;

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic carry;
        r = v;
        carry = 1'b1;
        if (v != SCORE_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*BCD_W +: BCD_W] == 4'd9) begin
                        r[i*BCD_W +: BCD_W] = 4'd0;
                    end else begin
                        r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_btn_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (!reset) sh <= '0;
        else        sh <= {sh[1:0], btn};
    end

    assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: sequences serve/play/pause/miss/over and owns
// lives, BCD score and speed level.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT     = 3,
    parameter int SERVE_FRAMES   = SERVE_FRAMES_DEF,
    parameter int MISS_FRAMES    = MISS_FRAMES_DEF,
    parameter int HITS_PER_LEVEL = 4,
    parameter int MAX_LEVEL      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        refresh_tick,
    input  logic        paddle_hit,
    input  logic        ball_miss,
    output logic        ball_run,
    output logic        ball_reload,
    output logic [2:0]  speed_level,
    output logic [15:0] score_bcd,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        paused
);

    localparam logic [15:0] SERVE_LAST = 16'(SERVE_FRAMES - 1);
    localparam logic [15:0] MISS_LAST  = 16'(MISS_FRAMES - 1);
    localparam logic [7:0]  HIT_LAST   = 8'(HITS_PER_LEVEL - 1);
    localparam logic [2:0]  LVL_MAX    = 3'(MAX_LEVEL);
    localparam logic [1:0]  LIVES_LD   = 2'(LIVES_INIT);

    state_t      state, state_n;
    logic [15:0] frame_cnt, frame_n;
    logic [7:0]  hit_cnt, hit_n;
    logic [15:0] score_n;
    logic [1:0]  lives_n;
    logic [2:0]  speed_n;
    logic        reload_n;
    logic        start_edge, pause_edge;

    btn_edge u_start (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .rise  (start_edge)
    );

    btn_edge u_pause (
        .clk   (clk),
        .reset (reset),
        .btn   (pause_btn),
        .rise  (pause_edge)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            hit_cnt     <= '0;
            score_bcd   <= '0;
            lives       <= '0;
            speed_level <= '0;
            ball_reload <= 1'b0;
            ball_run    <= 1'b0;
            game_over   <= 1'b0;
            paused      <= 1'b0;
        end else begin
            state       <= state_n;
            frame_cnt   <= frame_n;
            hit_cnt     <= hit_n;
            score_bcd   <= score_n;
            lives       <= lives_n;
            speed_level <= speed_n;
            ball_reload <= reload_n;
            ball_run    <= (state_n == PLAY);
            game_over   <= (state_n == OVER);
            paused      <= (state_n == PAUSE);
        end
    end

    always_comb begin
        state_n  = state;
        frame_n  = frame_cnt;
        hit_n    = hit_cnt;
        score_n  = score_bcd;
        lives_n  = lives;
        speed_n  = speed_level;
        reload_n = 1'b0;
        unique case (state)
            IDLE, OVER: begin
                if (start_edge) begin
                    lives_n  = LIVES_LD;
                    score_n  = '0;
                    speed_n  = '0;
                    hit_n    = '0;
                    frame_n  = '0;
                    reload_n = 1'b1;
                    state_n  = SERVE;
                end
            end
            SERVE: begin
                if (refresh_tick) begin
                    if (frame_cnt == SERVE_LAST) begin
                        frame_n = '0;
                        state_n = PLAY;
                    end else begin
                        frame_n = frame_cnt + 16'd1;
                    end
                end
            end
            PLAY: begin
                // A miss wins over both a same-cycle hit and a pause.
                if (ball_miss) begin
                    lives_n = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
                    frame_n = '0;
                    state_n = MISS;
                end else begin
                    if (paddle_hit) begin
                        score_n = bcd_inc(score_bcd);
                        if (hit_cnt == HIT_LAST) begin
                            hit_n = '0;
                            if (speed_level != LVL_MAX)
                                speed_n = speed_level + 3'd1;
                        end else begin
                            hit_n = hit_cnt + 8'd1;
                        end
                    end
                    if (pause_edge) state_n = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_edge) state_n = PLAY;
            end
            MISS: begin
                if (refresh_tick) begin
                    if (frame_cnt == MISS_LAST) begin
                        frame_n = '0;
                        if (lives == 2'd0) begin
                            state_n = OVER;
                        end else begin
                            speed_n  = '0;
                            hit_n    = '0;
                            reload_n = 1'b1;
                            state_n  = SERVE;
                        end
                    end else begin
                        frame_n = frame_cnt + 16'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game-flow controller for the VGA puck game. It sequences the ball/paddle pixel datapath through idle, serve, play, pause, miss and game-over phases. It owns the lives count, the 4-digit BCD score and the speed level, and it gates ball motion. The datapath reports collision events and consumes the run/reload/speed controls.

Parameters:
LIVES_INIT, 3, lives loaded at game start (1..3)
SERVE_FRAMES, 60, refresh ticks spent in SERVE before the ball moves
MISS_FRAMES, 30, refresh ticks spent in MISS before the next serve or game over
HITS_PER_LEVEL, 4, paddle hits per speed-level increment
MAX_LEVEL, 7, saturation value of speed_level

Ports:
clk  in  1  system pixel clock
reset  in  1  synchronous, active-low reset (0 = reset on the next rising clk edge)
start_btn  in  1  raw start button, asynchronous level
pause_btn  in  1  raw pause button, asynchronous level
refresh_tick  in  1  one-cycle pulse per frame, from the datapath
paddle_hit  in  1  one-cycle pulse per paddle collision
ball_miss  in  1  one-cycle pulse when the ball passes the right edge
ball_run  out  1  1 = datapath may advance the ball on refresh_tick
ball_reload  out  1  one-cycle pulse: datapath restores the ball to its serve position
speed_level  out  3  added to the ball x-velocity by the datapath
score_bcd  out  16  4 BCD digits; [15:12] is the thousands digit
lives  out  2  remaining lives
game_over  out  1  high while in OVER
paused  out  1  high while in PAUSE

Behaviour:
- Reset (reset=0 at a clk edge) forces the following values: state IDLE, all outputs 0, all counters 0, synchronizer flops 0.
- Button path: each button passes through a 2-flop synchronizer and then a rising-edge detector. The resulting edge pulse lasts 1 cycle and appears 3 clk edges after the raw rise. Holding a button produces only one edge.
- States and transitions:
  - IDLE: ball_run=0. On start_edge: lives←LIVES_INIT, score←0, speed_level←0, hit_cnt←0, frame_cnt←0, pulse ball_reload, go to SERVE.
  - SERVE: ball_run=0. frame_cnt increments on each refresh_tick. When a refresh_tick occurs with frame_cnt==SERVE_FRAMES-1: frame_cnt←0, go to PLAY.
  - PLAY: ball_run=1.
    - On paddle_hit: score increments in BCD, saturating at 9999. hit_cnt increments. When hit_cnt reaches HITS_PER_LEVEL: hit_cnt←0 and speed_level increments, saturating at MAX_LEVEL.
    - On ball_miss: lives←lives-1, frame_cnt←0, go to MISS.
    - On pause_edge: go to PAUSE.
  - PAUSE: ball_run=0, paused=1. Score and level are frozen, and paddle_hit/ball_miss are ignored. On pause_edge, return to PLAY.
  - MISS: ball_run=0. Counts refresh_ticks up to MISS_FRAMES, then:
    - lives==0 → OVER.
    - otherwise: speed_level←0, hit_cnt←0, pulse ball_reload, go to SERVE.
  - OVER: game_over=1 and ball_run=0. Score is held for display. On start_edge, take the same initialisation and reload pulse as IDLE, then go to SERVE.
- BCD increment rule: a digit that reaches 9 wraps to 0 and carries into the next digit. At 9999 the score stays at 9999.
- Priority within one PLAY cycle:
  - ball_miss beats paddle_hit; the hit is dropped.
  - ball_miss beats pause_edge.
  - paddle_hit together with pause_edge: the hit is counted, then the block enters PAUSE.
- start_edge is ignored outside IDLE and OVER. pause_edge is ignored outside PLAY and PAUSE.
- Timing: all outputs are registered. ball_run changes on the clk edge that performs the state transition.
- Reset mid-game returns the block to IDLE within one cycle. ball_reload is not pulsed by reset.

Decomposition:
- Package game_pkg holds:
  - the state encoding: IDLE, SERVE, PLAY, PAUSE, MISS, OVER (3-bit);
  - BCD digit width 4 and the saturation constant 16'h9999;
  - default frame counts.
- Sub-module btn_edge: synchronizer plus rising-edge detector with the same clk and reset. It is instantiated once for start and once for pause.

Test Plan:
1. Reset, then start rise → ball_reload pulse on edge 3, lives=3, SERVE entered. After 60 refresh_ticks: PLAY, ball_run=1.
2. In PLAY, 4 paddle_hits → score_bcd=16'h0004, speed_level=1. Preload score 0x0099 plus 1 hit → 0x0100. Preload 0x9999 plus 1 hit → stays 0x9999.
3. ball_miss and paddle_hit in the same cycle with lives=3 → lives=2, score unchanged, MISS entered. After 30 ticks: ball_reload pulse, speed_level=0, SERVE.
4. Three misses from a start → OVER, game_over=1, score held. Then start → SERVE with lives=3 and score 0.
5. pause rise in PLAY → paused=1, ball_run=0, hits ignored. Second pause rise → PLAY. Holding pause for 100 cycles toggles it only once.
6. reset=0 for one cycle mid-PLAY with score 0x0012 → next cycle IDLE, all outputs 0, no ball_reload.
